// File: rtl/myproject_sdiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// myproject_sdiv_pkg : shared types and constants for the 32s/18s -> 14s divider
// Revision: 1.0
// ---------------------------------------------------------------------------
package myproject_sdiv_pkg;

  localparam int DIN0_W = 32;
  localparam int DIN1_W = 18;
  localparam int DOUT_W = 14;
  localparam int ITER   = DIN0_W;
  localparam int MAGW   = DIN0_W + 1;
  localparam int CNTW   = $clog2(ITER);
  localparam int QMAX   = 8191;
  localparam int QMIN   = -8192;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/myproject_sat_14s.sv
`default_nettype none
// ---------------------------------------------------------------------------
// myproject_sat_14s : sign+magnitude quotient -> saturated 14-bit signed value
// Revision: 1.0
// ---------------------------------------------------------------------------
module myproject_sat_14s
  import myproject_sdiv_pkg::*;
(
  input  logic              neg_i,
  input  logic [MAGW-1:0]   mag_i,
  output logic [DOUT_W-1:0] q_o,
  output logic              ovf_o
);

  always_comb begin
    q_o   = '0;
    ovf_o = 1'b0;
    if (!neg_i) begin
      if (mag_i > MAGW'(QMAX)) begin
        q_o   = DOUT_W'(QMAX);
        ovf_o = 1'b1;
      end else begin
        q_o   = mag_i[DOUT_W-1:0];
      end
    end else begin
      // -QMIN is the largest magnitude that still fits as a negative value
      if (mag_i > MAGW'(-QMIN)) begin
        q_o   = DOUT_W'(QMIN);
        ovf_o = 1'b1;
      end else begin
        q_o   = ~mag_i[DOUT_W-1:0] + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/myproject_sdiv_seq_32s_18s_14s.sv
`default_nettype none
// ---------------------------------------------------------------------------
// myproject_sdiv_seq_32s_18s_14s : iterative restoring signed divider, valid/ready
// Revision: 1.0
// ---------------------------------------------------------------------------
module myproject_sdiv_seq_32s_18s_14s
  import myproject_sdiv_pkg::*;
#(
  parameter int unsigned ID         = 32'd1,
  parameter int          din0_WIDTH = DIN0_W,
  parameter int          din1_WIDTH = DIN1_W,
  parameter int          dout_WIDTH = DOUT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz
);

  state_e              state_q;
  logic [CNTW-1:0]     cnt_q;
  logic [MAGW-1:0]     dq_q;
  logic [DIN1_W-1:0]   dmag_q;
  logic [DIN1_W-1:0]   prem_q;
  logic                s0_q, s1_q;
  logic                in_ready_q, out_valid_q, ovf_q, dbz_q;
  logic [DOUT_W-1:0]   quot_q;
  logic [DIN1_W-1:0]   rem_q;

  logic [MAGW-1:0]     w_ext0, w_mag0;
  logic [DIN1_W-1:0]   w_mag1;
  logic [DIN1_W:0]     w_trial, w_diff;
  logic                w_ge;
  logic [DIN1_W-1:0]   prem_d, rem_d;
  logic [MAGW-1:0]     dq_d;
  logic [DOUT_W-1:0]   w_sat_q;
  logic                w_sat_ovf;

  // Magnitudes are one bit wider than the operands so -2^31 and -2^17 stay exact
  assign w_ext0 = {din0[DIN0_W-1], din0};
  assign w_mag0 = din0[DIN0_W-1] ? (~w_ext0 + 1'b1) : w_ext0;
  assign w_mag1 = din1[DIN1_W-1] ? (~din1 + 1'b1) : din1;

  assign w_trial = {prem_q, dq_q[ITER-1]};
  assign w_diff  = w_trial - {1'b0, dmag_q};
  assign w_ge    = (w_trial >= {1'b0, dmag_q});
  assign prem_d  = w_ge ? w_diff[DIN1_W-1:0] : w_trial[DIN1_W-1:0];
  assign dq_d    = {dq_q[MAGW-2:0], w_ge};
  assign rem_d   = s0_q ? (~prem_d + 1'b1) : prem_d;

  myproject_sat_14s u_sat (
    .neg_i (s0_q ^ s1_q),
    .mag_i ({1'b0, dq_d[ITER-1:0]}),
    .q_o   (w_sat_q),
    .ovf_o (w_sat_ovf)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dq_q        <= '0;
      dmag_q      <= '0;
      prem_q      <= '0;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            s0_q       <= din0[DIN0_W-1];
            s1_q       <= din1[DIN1_W-1];
            dq_q       <= w_mag0;
            dmag_q     <= w_mag1;
            prem_q     <= '0;
            cnt_q      <= CNTW'(ITER - 1);
            if (din1 == '0) begin
              // out_valid follows one edge later from DONE
              state_q <= DONE;
              dbz_q   <= 1'b1;
              ovf_q   <= 1'b0;
              rem_q   <= '0;
              quot_q  <= din0[DIN0_W-1] ? DOUT_W'(QMIN) : DOUT_W'(QMAX);
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          prem_q <= prem_d;
          dq_q   <= dq_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            quot_q      <= w_sat_q;
            ovf_q       <= w_sat_ovf;
            rem_q       <= rem_d;
            dbz_q       <= 1'b0;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_myproject_sdiv_seq_32s_18s_14s.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_myproject_sdiv_seq_32s_18s_14s : directed self-checking bench for the divider
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_myproject_sdiv_seq_32s_18s_14s;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] din0 = '0;
  logic [17:0] din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] quot;
  logic [17:0] rem;
  logic        ovf;
  logic        dbz;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  myproject_sdiv_seq_32s_18s_14s #(
    .ID(32'd1), .din0_WIDTH(32), .din1_WIDTH(18), .dout_WIDTH(14)
  ) dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands at a negedge and let the next rising edge accept them
  task automatic accept(input string tag, input logic [31:0] a, input logic [17:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready"}, in_ready, 1);
    din0 = a; din1 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    din0 = $urandom;
    din1 = 18'($urandom);
    check({tag, " busy"}, in_ready, 0);
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [17:0] b,
                         input int eq, input int er, input logic eovf,
                         input logic edbz, input int elat);
    int n = 0;
    accept(tag, a, b);
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, elat);
    check({tag, " quot"}, $signed(quot), eq);
    check({tag, " rem"}, $signed(rem), er);
    check({tag, " ovf"}, ovf, eovf);
    check({tag, " dbz"}, dbz, edbz);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " drop"}, out_valid, 0);
    check({tag, " ready"}, in_ready, 1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst quot", quot, 0);
    check("rst rem", rem, 0);
    check("rst ovf", ovf, 0);
    check("rst dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel in_ready low", in_ready, 0);
    @(posedge clk); #1;
    check("rel in_ready high", in_ready, 1);

    run_div("1000/7",    32'd1000,  18'd7,       142,   6,  1'b0, 1'b0, 32);
    run_div("-1000/7",   -32'sd1000, 18'd7,     -142,  -6,  1'b0, 1'b0, 32);
    run_div("1000/-7",   32'd1000,  -18'sd7,    -142,   6,  1'b0, 1'b0, 32);
    run_div("max/1",     32'h7FFF_FFFF, 18'd1,   8191,  0,  1'b1, 1'b0, 32);
    run_div("min/-1",    32'h8000_0000, -18'sd1, 8191,  0,  1'b1, 1'b0, 32);
    run_div("min/1",     32'h8000_0000, 18'd1,  -8192,  0,  1'b1, 1'b0, 32);
    run_div("8192/1",    32'd8192,  18'd1,       8191,  0,  1'b1, 1'b0, 32);
    run_div("-16384/2",  -32'sd16384, 18'd2,    -8192,  0,  1'b0, 1'b0, 32);
    run_div("1e6/-2^17", 32'd1000000, 18'h20000,   -7, 82496, 1'b0, 1'b0, 32);
    run_div("5/0",       32'd5,     18'd0,       8191,  0,  1'b0, 1'b1, 1);
    run_div("-5/0",      -32'sd5,   18'd0,      -8192,  0,  1'b0, 1'b1, 1);

    // Result must stay frozen while downstream stalls
    begin
      int n = 0;
      accept("hold", 32'd100, 18'd3);
      while (!out_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("hold latency", n, 32);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        in_valid = ~in_valid;
        din0 = 32'd7; din1 = 18'd1;
        @(posedge clk); #1;
        check("hold valid", out_valid, 1);
        check("hold in_ready", in_ready, 0);
        check("hold quot", $signed(quot), 33);
        check("hold rem", $signed(rem), 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hold release valid", out_valid, 0);
      check("hold release ready", in_ready, 1);
    end

    // Asynchronous reset in the middle of an operation
    accept("midrst", 32'd1000, 18'd7);
    repeat (16) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst in_ready", in_ready, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst quot", quot, 0);
    check("midrst rem", rem, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst ready low", in_ready, 0);
    @(posedge clk); #1;
    check("midrst ready high", in_ready, 1);
    run_div("100/-3", 32'd100, -18'sd3, -33, 1, 1'b0, 1'b0, 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
